// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared loader/cpu constants, loader state encoding and length rule
package prog_loader_pkg;

  localparam int LOADER_AW = 10;
  localparam int INSTR_W   = 16;
  localparam int LEN_W     = 11;

  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_CHK     = 3'd4,
    ST_RUN     = 3'd5,
    ST_ERROR   = 3'd6
  } ld_state_t;

  // Upper five bits of LEN_HI are reserved; any set bit rejects the load.
  function automatic logic len_ok(input logic [7:0] hi, input logic [7:0] lo, input int aw);
    logic [LEN_W-1:0] n;
    n = {hi[2:0], lo};
    return (hi[7:3] == 5'd0) && (n != '0) && (int'(n) <= (1 << aw));
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream input and program-memory write port of the loader
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int AW = LOADER_AW,
  parameter int DW = INSTR_W
);

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata
  );

endinterface

// File: rtl/loader_xsum.sv
// rtl/loader_xsum.sv - running XOR of accepted data bytes
module loader_xsum (
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (clear) begin
      sum <= 8'h00;
    end else if (enable) begin
      sum <= sum ^ din;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - parses a length/data/checksum byte stream into program memory, then releases the cpu
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int AW = LOADER_AW,
  parameter int DW = INSTR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reload,
  output logic          cpu_reset,
  output logic          err,
  prog_loader_if.master bus
);

  ld_state_t        state_q, state_d;
  logic             xfer;
  logic             take_reload;
  logic             xsum_clear;
  logic             xsum_en;
  logic [7:0]       xsum;
  logic [7:0]       len_hi_q;
  logic [7:0]       hi_q;
  logic [LEN_W-1:0] n_q;
  logic [LEN_W-1:0] cnt_q;
  logic             we_q;
  logic [AW-1:0]    waddr_q;
  logic [DW-1:0]    wdata_q;

  assign bus.in_ready = (state_q != ST_RUN) && (state_q != ST_ERROR);
  assign xfer         = bus.in_valid & bus.in_ready;
  assign cpu_reset    = (state_q != ST_RUN);
  assign err          = (state_q == ST_ERROR);
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign xsum_clear   = ~reset | take_reload;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_LEN_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    take_reload = 1'b0;
    xsum_en     = 1'b0;
    case (state_q)
      ST_LEN_HI: begin
        if (xfer) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (xfer) state_d = len_ok(len_hi_q, bus.in_data, AW) ? ST_DATA_HI : ST_ERROR;
      end
      ST_DATA_HI: begin
        if (xfer) begin
          xsum_en = 1'b1;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (xfer) begin
          xsum_en = 1'b1;
          state_d = (cnt_q == (n_q - LEN_W'(1))) ? ST_CHK : ST_DATA_HI;
        end
      end
      ST_CHK: begin
        if (xfer) state_d = (bus.in_data == xsum) ? ST_RUN : ST_ERROR;
      end
      ST_RUN, ST_ERROR: begin
        if (reload) begin
          take_reload = 1'b1;
          state_d     = ST_LEN_HI;
        end
      end
      default: state_d = ST_LEN_HI;
    endcase
  end

  // Write port is registered: the word appears one cycle after its low byte is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_hi_q <= 8'h00;
      hi_q     <= 8'h00;
      n_q      <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      we_q <= 1'b0;
      if (xfer) begin
        case (state_q)
          ST_LEN_HI: len_hi_q <= bus.in_data;
          ST_LEN_LO: begin
            n_q   <= {len_hi_q[2:0], bus.in_data};
            cnt_q <= '0;
          end
          ST_DATA_HI: hi_q <= bus.in_data;
          ST_DATA_LO: begin
            we_q    <= 1'b1;
            waddr_q <= cnt_q[AW-1:0];
            wdata_q <= {hi_q, bus.in_data};
            cnt_q   <= cnt_q + LEN_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  loader_xsum u_xsum (
    .clk    (clk),
    .clear  (xsum_clear),
    .enable (xsum_en),
    .din    (bus.in_data),
    .sum    (xsum)
  );

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter AW, default 10, meaning program-memory address width (1024 words).
REQ-002 SHALL have parameter DW, default 16, meaning instruction width; DW SHALL equal 16.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 SHALL have port in_valid  input  1  byte-stream source has a byte on in_data.
REQ-006 SHALL have port in_data  input  8  stream byte.
REQ-007 SHALL have port in_ready  output  1  loader accepts the byte; transfer = in_valid & in_ready on a rising edge.
REQ-008 SHALL have port reload  input  1  restart request, honoured only in RUN or ERROR.
REQ-009 SHALL have port we  output  1  program-memory write enable, one-cycle pulse.
REQ-010 SHALL have port waddr  output  AW  program-memory write address.
REQ-011 SHALL have port wdata  output  DW  program-memory write data.
REQ-012 SHALL have port cpu_reset  output  1  active-high reset to the cpu; 1 except in RUN.
REQ-013 SHALL have port err  output  1  load failed (bad length or checksum).

Function
REQ-014 Stream format SHALL be: LEN_HI, LEN_LO (word count N, big-endian, 11 bits used), then N words each as HI byte then LO byte, then one XOR checksum byte.
REQ-015 FSM states SHALL be LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, RUN, ERROR.
REQ-016 in_ready SHALL be 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK and 0 in RUN and ERROR.
REQ-017 LEN_HI -> LEN_LO on transfer; bits [7:3] of LEN_HI nonzero SHALL still be captured but force ERROR after LEN_LO.
REQ-018 LEN_LO transfer: N = {LEN_HI[2:0], LEN_LO}; N = 0 or N > 2**AW -> ERROR; else -> DATA_HI with word counter and address = 0.
REQ-019 DATA_HI transfer SHALL latch the high byte -> DATA_LO.
REQ-020 DATA_LO transfer SHALL register we = 1, wdata = {hi, lo}, waddr = counter in the next cycle (one-cycle latency), then increment counter.
REQ-021 After the Nth word -> CHK; otherwise -> DATA_HI; waddr SHALL never wrap within one load.
REQ-022 Checksum = XOR of every data byte (length bytes excluded); CHK transfer equal -> RUN, unequal -> ERROR.
REQ-023 we SHALL be 0 in every cycle not immediately following a DATA_LO transfer; waddr/wdata SHALL hold last values otherwise.
REQ-024 err SHALL be 1 exactly while in ERROR; cpu_reset SHALL be 0 exactly while in RUN.
REQ-025 reload = 1 in RUN or ERROR SHALL go to LEN_HI next cycle, cpu_reset = 1, err = 0, checksum cleared; reload ignored in other states.
REQ-026 in_valid without in_ready SHALL have no effect; in_valid gaps between bytes SHALL be allowed indefinitely.

Reset
REQ-027 reset = 0 SHALL force LEN_HI, counter 0, checksum 0, we 0, waddr 0, wdata 0, cpu_reset 1, err 0, in_ready 1 after the next edge, overriding any transfer in progress.
REQ-028 Reset mid-load SHALL discard the partial load; memory already written is not cleared.

Structure
REQ-029 State encodings, the 16-bit instruction width and AW default SHALL be defined in a shared header alongside the cpu constants.
REQ-030 Checksum accumulator SHALL be a sub-module loader_xsum (clear, enable, byte in, 8-bit sum out).

Verification
REQ-031 Stream 00 02 12 34 AB CD (12^34^AB^CD=40) 40 -> we at addr 0 data 1234, addr 1 data ABCD, then cpu_reset 0, err 0.
REQ-032 Stream 00 00 -> ERROR, err 1, no we pulse, in_ready 0.
REQ-033 Stream 04 01 (N = 1025) -> ERROR; stream 00 01 00 01 FF -> ERROR after checksum (expected 01).
REQ-034 Full load N = 1024 -> last write at waddr 3FF, RUN reached.
REQ-035 reset = 0 after first data word -> LEN_HI; new valid stream then loads correctly from addr 0.
REQ-036 reload pulsed in RUN with in_valid held high -> cpu_reset 1 next cycle, next transfer treated as LEN_HI; random in_valid gaps yield identical writes.
